// File: rtl/our_onehot_gray_receiver.sv
// One-hot to Gray re-encoder with a bit-serial Gray-to-binary stage and valid/ready output.
// Optional sequence checker enabled by defining OUR_SEQ_CHECK_EN.
module our_onehot_gray_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_onehot,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_gray,
  output logic [3:0]  out_binary,
  output logic        out_err,
  output logic        seq_err,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
  // in_ready depends only on state, and out_valid holds until out_ready is seen.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  b_q, b_d;
  logic        err_q, err_d;
  logic [3:0]  out_gray_q, out_gray_d;
  logic [3:0]  out_binary_q, out_binary_d;
  logic        out_err_q, out_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [3:0]  hi_idx;
  logic [4:0]  ones;
  logic [3:0]  b_n;
`ifdef OUR_SEQ_CHECK_EN
  logic        seq_err_q, seq_err_d;
  logic [3:0]  last_bin_q, last_bin_d;
  logic        has_ref_q, has_ref_d;
`endif

  always_comb begin
    hi_idx = 4'd0;
    ones   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (in_onehot[i]) begin
        hi_idx = 4'(i);
        ones   = ones + 5'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    g_d          = g_q;
    b_d          = b_q;
    err_d        = err_q;
    out_gray_d   = out_gray_q;
    out_binary_d = out_binary_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    b_n          = b_q;
`ifdef OUR_SEQ_CHECK_EN
    seq_err_d    = seq_err_q;
    last_bin_d   = last_bin_q;
    has_ref_d    = has_ref_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          g_d     = hi_idx;
          err_d   = (ones != 5'd1);
          b_d     = {hi_idx[3], 3'b000};
          step_d  = 2'd2;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        b_n[step_q] = b_q[step_q + 2'd1] ^ g_q[step_q];
        b_d         = b_n;
        if (step_q == 2'd0) begin
          state_d      = S_HOLD;
          out_gray_d   = g_q;
          out_binary_d = b_n;
          out_err_d    = err_q;
`ifdef OUR_SEQ_CHECK_EN
          seq_err_d    = has_ref_q && !err_q && (b_n != last_bin_q + 4'd1);
`endif
        end else begin
          step_d = step_q - 2'd1;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
          if (out_err_q && (err_count_q != 8'hff))
            err_count_d = err_count_q + 8'd1;
`ifdef OUR_SEQ_CHECK_EN
          // Only clean words become the reference for the next comparison.
          if (!out_err_q) begin
            last_bin_d = out_binary_q;
            has_ref_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= 2'd0;
      g_q          <= 4'd0;
      b_q          <= 4'd0;
      err_q        <= 1'b0;
      out_gray_q   <= 4'd0;
      out_binary_q <= 4'd0;
      out_err_q    <= 1'b0;
      err_count_q  <= 8'd0;
`ifdef OUR_SEQ_CHECK_EN
      seq_err_q    <= 1'b0;
      last_bin_q   <= 4'd0;
      has_ref_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      g_q          <= g_d;
      b_q          <= b_d;
      err_q        <= err_d;
      out_gray_q   <= out_gray_d;
      out_binary_q <= out_binary_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
`ifdef OUR_SEQ_CHECK_EN
      seq_err_q    <= seq_err_d;
      last_bin_q   <= last_bin_d;
      has_ref_q    <= has_ref_d;
`endif
    end
  end

  assign out_gray   = out_gray_q;
  assign out_binary = out_binary_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;
  assign dbg_state  = state_q;
`ifdef OUR_SEQ_CHECK_EN
  assign seq_err    = seq_err_q;
`else
  assign seq_err    = 1'b0;
`endif

endmodule
